piso_tx: RTL and testbench
==========================

# piso_tx

Parallel-in/serial-out transmitter that accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out MSB-first, one bit per clock, with a framing strobe. Because it sends MSB-first, a shift-left serial receiver that samples `sout` while `sout_valid` is high holds `din` unchanged after the last bit. It sits on the transmit side of the team's serial links, between a parallel data source and a single-wire serial channel.

## Interface
- `WIDTH`, default 4: data word width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset.
- `din`  input  WIDTH  parallel word; sampled only on an accepted load.
- `load_valid`  input  1  source requests a load of `din`.
- `load_ready`  output  1  block can accept a load this cycle.
- `sout`  output  WIDTH-independent, 1  serial data, registered.
- `sout_valid`  output  1  high for every cycle that `sout` carries a frame bit, registered.
- `busy`  output  1  high while a frame is being shifted.
- `done`  output  1  single-cycle pulse coincident with the last bit of a frame.

## Operation
- States:
  - IDLE: no frame in progress.
  - SHIFT: data bits are being sent.
  - PARITY: present only with the parity macro; sends one parity bit.
- Load accept: a load occurs on a rising edge where `load_valid && load_ready`. On accept:
  - `din` is captured into the shift register.
  - The bit counter is cleared.
  - The state becomes SHIFT.
- `load_ready` is combinational and is high in two cases:
  - in IDLE;
  - in the final bit cycle of a frame (the last SHIFT cycle, or the PARITY cycle when parity is enabled).
  - It is low in all other cycles.
- SHIFT:
  - `sout` = shift register MSB and `sout_valid` = 1.
  - Each clock, the register shifts left by 1 with zero fill and the counter increments.
  - After WIDTH bits, the state goes to PARITY if enabled. Otherwise it goes to SHIFT if a new load was accepted that cycle, else to IDLE.
- Back-to-back frames: a load accepted in the final bit cycle starts the next frame's MSB on the very next cycle. There is no gap and `sout_valid` stays high.
- `load_valid` while `load_ready` is low is ignored. `din` is not sampled and no state changes.
- `done` is high exactly in the final bit cycle of each frame.
- `busy` = (state != IDLE).
- In IDLE: `sout` = 0 and `sout_valid` = 0.
- Bit counter width is $clog2(WIDTH+1). The counter never wraps within a frame.
- Reset values (asynchronous, whenever `rst` = 0):
  - state IDLE, shift register 0, counter 0;
  - `sout` 0, `sout_valid` 0, `busy` 0, `done` 0, `load_ready` 1.
- Loads are not accepted while `rst` is low.
- Reset mid-frame: the frame is discarded immediately. The block resumes in IDLE on the first edge after `rst` returns high.

## Timing
- A load accepted at edge N drives bit WIDTH-1 on `sout` during the cycle after edge N. Bit 0 appears in cycle N+WIDTH.
- Without parity, `done` is high in cycle N+WIDTH. With parity, the parity bit is in cycle N+WIDTH+1 and `done` is high in that cycle.
- Frame length is WIDTH cycles, or WIDTH+1 with parity.
- Sustained throughput is one frame per frame length, with zero idle cycles.
- `load_ready` → accept has a combinational path from state only. There is no combinational path from `load_valid` to any output.

## Configuration
- `PISO_TX_PARITY_EN` defined:
  - After the data bits, one extra bit equal to XOR of the captured word (even parity) is sent with `sout_valid` = 1.
  - `done` and the back-to-back `load_ready` window move to that parity cycle.
- `PISO_TX_PARITY_EN` undefined: the PARITY state and its logic are absent, and frames are exactly WIDTH bits.

## Test plan
- Single frame, WIDTH=4: load `din`=4'b1011 at edge N → `sout` = 1,0,1,1 in cycles N+1..N+4; `sout_valid` high for 4 cycles; `done` high only in N+4; then `busy` 0 and `sout` 0.
- Back-to-back frames: load 4'b1011, then hold `load_valid` with 4'b0110 → `sout` = 1,0,1,1,0,1,1,0 on 8 contiguous cycles; `sout_valid` never drops; `done` pulses in cycles 4 and 8.
- Ignored load: pulse `load_valid` with 4'b1111 in cycle 2 of a 4'b1011 frame → `load_ready` 0, stream unchanged, block idle after cycle 4.
- Reset mid-frame: drive `rst` low during bit 2 of 4'b1011 → `sout`, `sout_valid`, `busy` go to 0 without waiting for a clock. After release, load 4'b0101 → 0,1,0,1.
- Parity build, WIDTH=4: load 4'b1011 → `sout` = 1,0,1,1,1, with `done` on the fifth bit. Load 4'b0110 → parity bit 0.
- WIDTH=8: load 8'hA5 → 1,0,1,0,0,1,0,1; a shift-left receiver sampling on `sout_valid` reads 8'hA5.

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter, MSB first, optional even parity bit (`PISO_TX_PARITY_EN).
// Latency: first bit on sout the cycle after load accept; frame is WIDTH cycles (WIDTH+1 with parity).
// Backpressure: load_ready high only in IDLE or the final bit cycle; loads offered otherwise are ignored.
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             last_shift;
  logic             final_bit;
  logic             accept;
`ifdef PISO_TX_PARITY_EN
  logic             par;
`endif

  assign last_shift = (state == SHIFT) && (cnt == LAST_IDX);
`ifdef PISO_TX_PARITY_EN
  assign final_bit  = (state == PARITY);
`else
  assign final_bit  = last_shift;
`endif

  // Ready depends on state only, so load_valid never reaches an output combinationally.
  assign load_ready = (state == IDLE) || final_bit;
  assign accept     = load_valid && load_ready;
  assign done       = final_bit;
  assign busy       = (state != IDLE);
  // The shift register drains to zero at the end of a frame, so its MSB is already 0 in IDLE.
  assign sout       = sreg[WIDTH-1];

  // Next-state, shift and counter logic; an accepted load overrides the normal progression.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        state_nxt = IDLE;
      end
      SHIFT: begin
        sreg_nxt = sreg << 1;
        cnt_nxt  = cnt + 1'b1;
        if (last_shift) begin
`ifdef PISO_TX_PARITY_EN
          state_nxt = PARITY;
          sreg_nxt  = {par, {(WIDTH-1){1'b0}}};
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        state_nxt = IDLE;
        sreg_nxt  = '0;
      end
`endif
      default: begin
        state_nxt = IDLE;
        sreg_nxt  = '0;
      end
    endcase
    if (accept) begin
      state_nxt = SHIFT;
      sreg_nxt  = din;
      cnt_nxt   = '0;
    end
  end

  // State, data and strobe registers; reset discards any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      sout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      cnt        <= cnt_nxt;
      sout_valid <= (state_nxt != IDLE);
    end
  end

`ifdef PISO_TX_PARITY_EN
  // Even parity of the captured word, sent after the data bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par <= 1'b0;
    end else if (accept) begin
      par <= ^din;
    end
  end
`endif

endmodule

// File: tb/tb_piso_tx.sv
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL4 = 4 + PAR;
  localparam int FL8 = 8 + PAR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] din4;
  logic       lv4;
  logic       lr4, so4, sv4, b4, d4;
  logic [7:0] din8;
  logic       lv8;
  logic       lr8, so8, sv8, b8, d8;

  int total = 0;
  int bad   = 0;

  piso_tx #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .din(din4), .load_valid(lv4), .load_ready(lr4),
    .sout(so4), .sout_valid(sv4), .busy(b4), .done(d4)
  );

  piso_tx #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .din(din8), .load_valid(lv8), .load_ready(lr8),
    .sout(so8), .sout_valid(sv8), .busy(b8), .done(d8)
  );

  // Expected serial bit i of a frame: data MSB first, then even parity if enabled.
  function automatic logic exp_bit4(input logic [3:0] w, input int i);
    if (i < 4) return w[3-i];
    return ^w;
  endfunction

  function automatic logic exp_bit8(input logic [7:0] w, input int i);
    if (i < 8) return w[7-i];
    return ^w;
  endfunction

  task automatic test_reset();
    rst = 1'b0; din4 = '0; lv4 = 1'b0; din8 = '0; lv8 = 1'b0;
    #2;
    total++; if (so4 !== 1'b0) begin bad++; $display("FAIL reset_sout got=%b want=0", so4); end
    total++; if (sv4 !== 1'b0) begin bad++; $display("FAIL reset_sout_valid got=%b want=0", sv4); end
    total++; if (b4 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", b4); end
    total++; if (d4 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", d4); end
    total++; if (lr4 !== 1'b1) begin bad++; $display("FAIL reset_load_ready got=%b want=1", lr4); end
    total++; if (lr8 !== 1'b1 || b8 !== 1'b0) begin bad++; $display("FAIL reset_w8 ready=%b busy=%b want 1/0", lr8, b8); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] w;
    w = 4'b1011;
    @(posedge clk); #1 din4 = w; lv4 = 1'b1;
    @(negedge clk);
    total++; if (lr4 !== 1'b1) begin bad++; $display("FAIL single_idle_ready got=%b want=1", lr4); end
    @(posedge clk); #1 lv4 = 1'b0; din4 = '0;
    for (int i = 0; i < FL4; i++) begin
      @(negedge clk);
      total++; if (so4 !== exp_bit4(w, i)) begin bad++; $display("FAIL single_sout bit%0d got=%b want=%b", i, so4, exp_bit4(w, i)); end
      total++; if (sv4 !== 1'b1 || b4 !== 1'b1) begin bad++; $display("FAIL single_valid_busy bit%0d got=%b%b want=11", i, sv4, b4); end
      total++; if (d4 !== (i == FL4-1)) begin bad++; $display("FAIL single_done bit%0d got=%b want=%b", i, d4, (i == FL4-1)); end
      total++; if (lr4 !== (i == FL4-1)) begin bad++; $display("FAIL single_ready bit%0d got=%b want=%b", i, lr4, (i == FL4-1)); end
    end
    @(negedge clk);
    total++; if (b4 !== 1'b0 || so4 !== 1'b0 || sv4 !== 1'b0) begin bad++; $display("FAIL single_idle busy=%b sout=%b vld=%b want 000", b4, so4, sv4); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w0, w1;
    logic       e;
    w0 = 4'b1011; w1 = 4'b0110;
    @(posedge clk); #1 din4 = w0; lv4 = 1'b1;
    @(posedge clk); #1 din4 = w1;
    for (int i = 0; i < 2*FL4; i++) begin
      @(negedge clk);
      e = (i < FL4) ? exp_bit4(w0, i) : exp_bit4(w1, i - FL4);
      total++; if (so4 !== e) begin bad++; $display("FAIL b2b_sout bit%0d got=%b want=%b", i, so4, e); end
      total++; if (sv4 !== 1'b1) begin bad++; $display("FAIL b2b_valid bit%0d got=%b want=1", i, sv4); end
      total++; if (d4 !== (i == FL4-1 || i == 2*FL4-1)) begin bad++; $display("FAIL b2b_done bit%0d got=%b want=%b", i, d4, (i == FL4-1 || i == 2*FL4-1)); end
      if (i == FL4) lv4 = 1'b0;
    end
    @(negedge clk);
    total++; if (b4 !== 1'b0 || sv4 !== 1'b0) begin bad++; $display("FAIL b2b_idle busy=%b vld=%b want 00", b4, sv4); end
  endtask

  task automatic test_ignored_load();
    logic [3:0] w;
    w = 4'b1011;
    @(posedge clk); #1 din4 = w; lv4 = 1'b1;
    @(posedge clk); #1 lv4 = 1'b0; din4 = '0;
    for (int i = 0; i < FL4; i++) begin
      @(negedge clk);
      total++; if (so4 !== exp_bit4(w, i)) begin bad++; $display("FAIL ignored_sout bit%0d got=%b want=%b", i, so4, exp_bit4(w, i)); end
      if (i == 1) begin
        total++; if (lr4 !== 1'b0) begin bad++; $display("FAIL ignored_ready got=%b want=0", lr4); end
        din4 = 4'b1111; lv4 = 1'b1;
      end
      if (i == 2) begin lv4 = 1'b0; din4 = '0; end
    end
    @(negedge clk);
    total++; if (b4 !== 1'b0 || sv4 !== 1'b0) begin bad++; $display("FAIL ignored_idle busy=%b vld=%b want 00", b4, sv4); end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] w;
    @(posedge clk); #1 din4 = 4'b1011; lv4 = 1'b1;
    @(posedge clk); #1 lv4 = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    total++; if (so4 !== 1'b1 || b4 !== 1'b1) begin bad++; $display("FAIL midrst_pre sout=%b busy=%b want 11", so4, b4); end
    #1 rst = 1'b0;
    #1;
    total++; if (so4 !== 1'b0 || sv4 !== 1'b0 || b4 !== 1'b0) begin bad++; $display("FAIL midrst_async sout=%b vld=%b busy=%b want 000", so4, sv4, b4); end
    total++; if (lr4 !== 1'b1 || d4 !== 1'b0) begin bad++; $display("FAIL midrst_ready_done ready=%b done=%b want 10", lr4, d4); end
    din4 = 4'b1111; lv4 = 1'b1;
    @(posedge clk); @(negedge clk);
    total++; if (b4 !== 1'b0 || sv4 !== 1'b0) begin bad++; $display("FAIL midrst_noload busy=%b vld=%b want 00", b4, sv4); end
    lv4 = 1'b0; rst = 1'b1;
    @(negedge clk);
    total++; if (b4 !== 1'b0) begin bad++; $display("FAIL midrst_release busy=%b want 0", b4); end
    w = 4'b0101;
    @(posedge clk); #1 din4 = w; lv4 = 1'b1;
    @(posedge clk); #1 lv4 = 1'b0; din4 = '0;
    for (int i = 0; i < FL4; i++) begin
      @(negedge clk);
      total++; if (so4 !== exp_bit4(w, i) || sv4 !== 1'b1) begin bad++; $display("FAIL midrst_frame bit%0d got=%b/%b want=%b/1", i, so4, sv4, exp_bit4(w, i)); end
    end
    @(negedge clk);
  endtask

  task automatic test_width8();
    logic [7:0] w, rx;
    w = 8'hA5; rx = '0;
    @(posedge clk); #1 din8 = w; lv8 = 1'b1;
    @(posedge clk); #1 lv8 = 1'b0; din8 = '0;
    for (int i = 0; i < FL8; i++) begin
      @(negedge clk);
      total++; if (so8 !== exp_bit8(w, i)) begin bad++; $display("FAIL w8_sout bit%0d got=%b want=%b", i, so8, exp_bit8(w, i)); end
      total++; if (d8 !== (i == FL8-1) || sv8 !== 1'b1) begin bad++; $display("FAIL w8_done_valid bit%0d got=%b%b want=%b1", i, d8, sv8, (i == FL8-1)); end
      if (i < 8 && sv8) rx = {rx[6:0], so8};
    end
    total++; if (rx !== w) begin bad++; $display("FAIL w8_receiver got=%h want=%h", rx, w); end
    @(negedge clk);
    total++; if (b8 !== 1'b0 || sv8 !== 1'b0) begin bad++; $display("FAIL w8_idle busy=%b vld=%b want 00", b8, sv8); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignored_load();
    test_reset_mid_frame();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
